// File: rtl/uop_retire_sched.sv
// uop_retire_sched: pops retired-instruction entries from the uop FIFO and
// groups runs of sequential instructions into one trace packet. A block is
// closed by a non-STD itype, a privilege change or retire-counter saturation.
// The packet is then held on a valid/ready handshake until the encoder
// accepts it.
//
// fifo_entry_i layout, MSB first: {valid, pc[XLEN], itype[ITYPE_LEN], compressed, priv[PRIV_LEN]}
// exc_info_i layout, MSB first:   {cause[XLEN], tval[XLEN]}
//
// Optional feature macro: TE_CONN_EXC_INFO_EN. When it is defined, cause/tval
// are latched from EXC/INT entries. When it is undefined, cause/tval are
// constant zero.
module uop_retire_sched #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ITYPE_LEN   = 4,
  parameter int unsigned PRIV_LEN    = 2,
  parameter int unsigned IRETIRE_LEN = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               fifo_empty_i,
  input  logic [XLEN+ITYPE_LEN+PRIV_LEN+1:0] fifo_entry_i,
  output logic                               fifo_pop_o,
  input  logic [2*XLEN-1:0]                  exc_info_i,
  output logic                               pkt_valid_o,
  input  logic                               pkt_ready_i,
  output logic [XLEN-1:0]                    pkt_iaddr_o,
  output logic [IRETIRE_LEN-1:0]             pkt_iretire_o,
  output logic [ITYPE_LEN-1:0]               pkt_itype_o,
  output logic                               pkt_ilastsize_o,
  output logic [PRIV_LEN-1:0]                pkt_priv_o,
  output logic [XLEN-1:0]                    pkt_cause_o,
  output logic [XLEN-1:0]                    pkt_tval_o
);

  localparam int unsigned EntryW = XLEN + ITYPE_LEN + PRIV_LEN + 2;

  localparam logic [ITYPE_LEN-1:0] ItypeStd = '0;
  localparam logic [ITYPE_LEN-1:0] ItypeExc = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0] ItypeInt = ITYPE_LEN'(2);

  typedef enum logic [1:0] {StIdle, StCount, StEmit} state_e;

  state_e                 state_q, state_d;
  logic [IRETIRE_LEN-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]        iaddr_q, iaddr_d;
  logic [ITYPE_LEN-1:0]   itype_q, itype_d;
  logic [PRIV_LEN-1:0]    priv_q, priv_d;
  logic                   last_q, last_d;

  // Head entry fields
  logic                   head_valid;
  logic [XLEN-1:0]        head_pc;
  logic [ITYPE_LEN-1:0]   head_itype;
  logic                   head_c;
  logic [PRIV_LEN-1:0]    head_priv;
  logic                   head_is_exc;
  logic                   head_ok;
  logic                   head_drop;

  assign head_valid  = fifo_entry_i[EntryW-1];
  assign head_pc     = fifo_entry_i[PRIV_LEN+ITYPE_LEN+1 +: XLEN];
  assign head_itype  = fifo_entry_i[PRIV_LEN+1 +: ITYPE_LEN];
  assign head_c      = fifo_entry_i[PRIV_LEN];
  assign head_priv   = fifo_entry_i[PRIV_LEN-1:0];
  assign head_is_exc = (head_itype == ItypeExc) || (head_itype == ItypeInt);
  assign head_ok     = !fifo_empty_i && head_valid;
  assign head_drop   = !fifo_empty_i && !head_valid;

  // Halfword increment for the head entry. The extra bit of cnt_sum flags saturation.
  logic [IRETIRE_LEN-1:0] inc;
  logic [IRETIRE_LEN:0]   cnt_sum;
  assign inc     = head_c ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
  assign cnt_sum = {1'b0, cnt_q} + {1'b0, inc};

  logic latch_type;  // closing entry with a non-STD itype is being popped
  logic handshake;

  // Next-state and pop decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    iaddr_d    = iaddr_q;
    itype_d    = itype_q;
    priv_d     = priv_q;
    last_d     = last_q;
    fifo_pop_o = 1'b0;
    latch_type = 1'b0;
    handshake  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (head_drop) begin
          fifo_pop_o = 1'b1;
        end else if (head_ok) begin
          fifo_pop_o = 1'b1;
          iaddr_d    = head_pc;
          priv_d     = head_priv;
          cnt_d      = inc;
          last_d     = !head_c;
          if (head_itype == ItypeStd) begin
            state_d = StCount;
          end else begin
            itype_d    = head_itype;
            latch_type = 1'b1;
            state_d    = StEmit;
          end
        end
      end
      StCount: begin
        if (head_drop) begin
          fifo_pop_o = 1'b1;
        end else if (head_ok) begin
          if (head_priv != priv_q || cnt_sum[IRETIRE_LEN]) begin
            // Leave the head entry in the FIFO; it opens the next block.
            itype_d = ItypeStd;
            state_d = StEmit;
          end else begin
            fifo_pop_o = 1'b1;
            cnt_d      = cnt_sum[IRETIRE_LEN-1:0];
            last_d     = !head_c;
            if (head_itype != ItypeStd) begin
              itype_d    = head_itype;
              latch_type = 1'b1;
              state_d    = StEmit;
            end
          end
        end
      end
      StEmit: begin
        if (pkt_ready_i) begin
          handshake = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Block state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      iaddr_q <= '0;
      itype_q <= '0;
      priv_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iaddr_q <= iaddr_d;
      itype_q <= itype_d;
      priv_q  <= priv_d;
      last_q  <= last_d;
    end
  end

`ifdef TE_CONN_EXC_INFO_EN
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;

  // Capture exception info only from EXC/INT closers; any other packet carries zero.
  always_comb begin
    cause_d = cause_q;
    tval_d  = tval_q;
    if (handshake) begin
      cause_d = '0;
      tval_d  = '0;
    end else if (latch_type) begin
      if (head_is_exc) begin
        cause_d = exc_info_i[2*XLEN-1:XLEN];
        tval_d  = exc_info_i[XLEN-1:0];
      end else begin
        cause_d = '0;
        tval_d  = '0;
      end
    end
  end

  // Exception info registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      cause_q <= cause_d;
      tval_q  <= tval_d;
    end
  end

  assign pkt_cause_o = cause_q;
  assign pkt_tval_o  = tval_q;
`else
  logic unused_exc;
  assign unused_exc  = ^{exc_info_i, head_is_exc, latch_type, handshake};
  assign pkt_cause_o = '0;
  assign pkt_tval_o  = '0;
`endif

  assign pkt_valid_o     = (state_q == StEmit);
  assign pkt_iaddr_o     = iaddr_q;
  assign pkt_iretire_o   = cnt_q;
  assign pkt_itype_o     = itype_q;
  assign pkt_ilastsize_o = last_q;
  assign pkt_priv_o      = priv_q;

endmodule

// File: tb/tb_uop_retire_sched.sv
// Scoreboard bench for uop_retire_sched. The DUT runs with IRETIRE_LEN = 4 so
// that counter saturation is reachable. Stimulus pushes entries into a FIFO
// model and pushes the expected packets into a queue. A monitor compares each
// accepted packet against that queue.
module tb_uop_retire_sched;

  localparam int unsigned XL  = 64;
  localparam int unsigned IRL = 4;

`ifdef TE_CONN_EXC_INFO_EN
  localparam bit ExcEn = 1'b1;
`else
  localparam bit ExcEn = 1'b0;
`endif

  logic          clk;
  logic          rst_i;
  logic          fifo_empty_i;
  logic [71:0]   fifo_entry_i;
  logic          fifo_pop_o;
  logic [127:0]  exc_info_i;
  logic          pkt_valid_o;
  logic          pkt_ready_i;
  logic [63:0]   pkt_iaddr_o;
  logic [IRL-1:0] pkt_iretire_o;
  logic [3:0]    pkt_itype_o;
  logic          pkt_ilastsize_o;
  logic [1:0]    pkt_priv_o;
  logic [63:0]   pkt_cause_o;
  logic [63:0]   pkt_tval_o;

  uop_retire_sched #(
    .XLEN(XL), .ITYPE_LEN(4), .PRIV_LEN(2), .IRETIRE_LEN(IRL)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_entry_i   (fifo_entry_i),
    .fifo_pop_o     (fifo_pop_o),
    .exc_info_i     (exc_info_i),
    .pkt_valid_o    (pkt_valid_o),
    .pkt_ready_i    (pkt_ready_i),
    .pkt_iaddr_o    (pkt_iaddr_o),
    .pkt_iretire_o  (pkt_iretire_o),
    .pkt_itype_o    (pkt_itype_o),
    .pkt_ilastsize_o(pkt_ilastsize_o),
    .pkt_priv_o     (pkt_priv_o),
    .pkt_cause_o    (pkt_cause_o),
    .pkt_tval_o     (pkt_tval_o)
  );

  typedef struct {
    logic [63:0] iaddr;
    logic [63:0] iretire;
    logic [63:0] itype;
    logic [63:0] last;
    logic [63:0] priv;
    logic [63:0] cause;
    logic [63:0] tval;
  } pkt_t;

  pkt_t        exp_q[$];
  logic [71:0] fq[$];
  int          pop_cyc[$];
  int          hs_cyc[$];
  int          pops_at_hs[$];
  int          pop_cnt = 0;
  int          cyc = 0;
  bit          pop_pend = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic v, input logic [63:0] pc, input logic [3:0] it,
                                     input logic c, input logic [1:0] pr);
    return {v, pc, it, c, pr};
  endfunction

  task automatic refresh();
    fifo_empty_i = (fq.size() == 0);
    fifo_entry_i = (fq.size() != 0) ? fq[0] : 72'h0;
  endtask

  task automatic push(input logic [71:0] e);
    fq.push_back(e);
    refresh();
  endtask

  task automatic exp_pkt(input logic [63:0] iaddr, input logic [63:0] iret, input logic [63:0] it,
                         input logic [63:0] last, input logic [63:0] pr, input logic [63:0] cause,
                         input logic [63:0] tval);
    pkt_t p;
    p.iaddr = iaddr; p.iretire = iret; p.itype = it; p.last = last; p.priv = pr;
    p.cause = cause; p.tval = tval;
    exp_q.push_back(p);
  endtask

  task automatic clear_log();
    pop_cyc.delete();
    hs_cyc.delete();
    pops_at_hs.delete();
    pop_cnt = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(name, 64'(n < 200), 64'd1);
    repeat (2) @(posedge clk);
  endtask

  // Cycle counter and FIFO model: the head sampled as popped leaves after the edge
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (pop_pend && fq.size() != 0) begin
      void'(fq.pop_front());
      refresh();
    end
  end

  // Pop sampler, away from the active edge
  initial forever begin
    @(negedge clk);
    pop_pend = fifo_pop_o && !rst_i;
    if (fifo_empty_i) chk("pop_while_empty", 64'(fifo_pop_o), 64'd0);
    if (pop_pend) begin
      pop_cnt++;
      pop_cyc.push_back(cyc);
    end
  end

  // Monitor: compare every accepted packet against the scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst_i && pkt_valid_o && pkt_ready_i) begin
      hs_cyc.push_back(cyc);
      pops_at_hs.push_back(pop_cnt);
      if (exp_q.size() == 0) begin
        chk("unexpected_pkt_iaddr", pkt_iaddr_o, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        chk("pkt_iaddr", pkt_iaddr_o, e.iaddr);
        chk("pkt_iretire", 64'(pkt_iretire_o), e.iretire);
        chk("pkt_itype", 64'(pkt_itype_o), e.itype);
        chk("pkt_ilastsize", 64'(pkt_ilastsize_o), e.last);
        chk("pkt_priv", 64'(pkt_priv_o), e.priv);
        chk("pkt_cause", pkt_cause_o, e.cause);
        chk("pkt_tval", pkt_tval_o, e.tval);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i        = 1'b1;
    pkt_ready_i  = 1'b1;
    exc_info_i   = {64'h7, 64'h77};
    fifo_empty_i = 1'b1;
    fifo_entry_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(pkt_valid_o), 64'd0);
    chk("rst_pop", 64'(fifo_pop_o), 64'd0);
    chk("rst_iaddr", pkt_iaddr_o, 64'd0);
    chk("rst_iretire", 64'(pkt_iretire_o), 64'd0);
    chk("rst_itype", 64'(pkt_itype_o), 64'd0);
    chk("rst_priv", 64'(pkt_priv_o), 64'd0);
    chk("rst_ilastsize", 64'(pkt_ilastsize_o), 64'd0);
    chk("rst_cause", pkt_cause_o, 64'd0);
    chk("rst_tval", pkt_tval_o, 64'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    repeat (2) @(posedge clk);

    // 1: STD, STD(c), TB closes the block
    clear_log();
    @(posedge clk); #2;
    exp_pkt(64'h1000, 5, 5, 1, 3, 0, 0);
    push(mk(1, 64'h1000, 4'd0, 0, 2'd3));
    push(mk(1, 64'h1004, 4'd0, 1, 2'd3));
    push(mk(1, 64'h1006, 4'd5, 0, 2'd3));
    drain("t1_drain");
    chk("t1_pops", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3 && hs_cyc.size() == 1) begin
      chk("t1_pop_gap0", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
      chk("t1_pop_gap1", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
      chk("t1_valid_lat", 64'(hs_cyc[0] - pop_cyc[2]), 64'd1);
    end

    // 2: privilege change closes, the head entry opens the next block
    clear_log();
    @(posedge clk); #2;
    exp_pkt(64'h2000, 2, 0, 1, 3, 0, 0);
    exp_pkt(64'h2004, 4, 13, 1, 0, 0, 0);
    push(mk(1, 64'h2000, 4'd0, 0, 2'd3));
    push(mk(1, 64'h2004, 4'd0, 0, 2'd0));
    push(mk(1, 64'h2008, 4'd13, 0, 2'd0));
    drain("t2_drain");
    chk("t2_pops_at_hs1", (pops_at_hs.size() > 0) ? 64'(pops_at_hs[0]) : 64'hBAD, 64'd1);
    if (pop_cyc.size() == 3 && hs_cyc.size() == 2) begin
      chk("t2_priv_close_lat", 64'(hs_cyc[0] - pop_cyc[0]), 64'd2);
      chk("t2_bubble", 64'(pop_cyc[1] - hs_cyc[0]), 64'd1);
    end

    // 3: EXC under back-pressure
    clear_log();
    @(posedge clk); #2;
    pkt_ready_i = 1'b0;
    exc_info_i  = {64'h2, 64'hDEAD};
    exp_pkt(64'h3000, 2, 1, 1, 3, ExcEn ? 64'h2 : 64'h0, ExcEn ? 64'hDEAD : 64'h0);
    push(mk(1, 64'h3000, 4'd1, 0, 2'd3));
    begin
      int n = 0;
      while (!pkt_valid_o && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t3_valid_seen", 64'(pkt_valid_o), 64'd1);
    end
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      chk("t3_hold_valid", 64'(pkt_valid_o), 64'd1);
      chk("t3_hold_iaddr", pkt_iaddr_o, 64'h3000);
      chk("t3_hold_itype", 64'(pkt_itype_o), 64'd1);
      chk("t3_hold_iretire", 64'(pkt_iretire_o), 64'd2);
      chk("t3_hold_pops", 64'(pop_cnt), 64'd1);
    end
    @(posedge clk); #1;
    pkt_ready_i = 1'b1;
    drain("t3_drain");
    exc_info_i = {64'h7, 64'h77};

    // 4: saturation with a 4-bit counter
    clear_log();
    @(posedge clk); #2;
    exp_pkt(64'h4000, 14, 0, 1, 3, 0, 0);
    exp_pkt(64'h401C, 3, 13, 0, 3, 0, 0);
    for (int i = 0; i < 8; i++) push(mk(1, 64'h4000 + 64'(4 * i), 4'd0, 0, 2'd3));
    push(mk(1, 64'h4020, 4'd13, 1, 2'd3));
    drain("t4_drain");
    chk("t4_pops_at_hs1", (pops_at_hs.size() > 0) ? 64'(pops_at_hs[0]) : 64'hBAD, 64'd7);
    chk("t4_pops_at_hs2", (pops_at_hs.size() > 1) ? 64'(pops_at_hs[1]) : 64'hBAD, 64'd9);

    // 5: invalid entry is popped and ignored
    clear_log();
    @(posedge clk); #2;
    exp_pkt(64'h5000, 4, 13, 1, 3, 0, 0);
    push(mk(1, 64'h5000, 4'd0, 1, 2'd3));
    push(mk(0, 64'h0BAD, 4'd1, 0, 2'd1));
    push(mk(1, 64'h5002, 4'd0, 1, 2'd3));
    push(mk(1, 64'h5004, 4'd13, 0, 2'd3));
    drain("t5_drain");
    chk("t5_pops", 64'(pop_cnt), 64'd4);

    // 6: reset mid-COUNT drops the partial block
    clear_log();
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) push(mk(1, 64'h6100 + 64'(4 * i), 4'd0, 0, 2'd3));
    begin
      int n = 0;
      while (pop_cnt < 3 && n < 50) begin
        @(posedge clk);
        n++;
      end
      chk("t6_pops_before_rst", 64'(pop_cnt), 64'd3);
    end
    repeat (3) @(negedge clk);
    chk("t6_hold_no_valid", 64'(pkt_valid_o), 64'd0);
    chk("t6_hold_count", 64'(pkt_iretire_o), 64'd6);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("t6_after_rst_valid", 64'(pkt_valid_o), 64'd0);
    chk("t6_after_rst_count", 64'(pkt_iretire_o), 64'd0);
    chk("t6_after_rst_iaddr", pkt_iaddr_o, 64'd0);
    @(posedge clk); #2;
    exp_pkt(64'h6000, 2, 13, 0, 3, 0, 0);
    push(mk(1, 64'h6000, 4'd0, 1, 2'd3));
    push(mk(1, 64'h6002, 4'd13, 1, 2'd3));
    drain("t6_drain");
    chk("t6_pkt_count", 64'(hs_cyc.size()), 64'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
